// File: rtl/conv1_pkg.sv
// ---------------------------------------------------------------------------
// conv1_pkg
// Shared definitions for the first convolution layer:
//   - data widths for pixels, products, accumulated outputs and channel index
//   - pix_t / acc_t scalar types used at the MAC boundary
//   - state_t, the layer sequencer states
// ---------------------------------------------------------------------------
package conv1_pkg;

  localparam int IN_W     = 8;
  localparam int PROD_W   = 16;
  localparam int OUT_W    = 24;
  localparam int CH_IDX_W = 4;

  typedef logic signed [IN_W-1:0]  pix_t;
  typedef logic signed [OUT_W-1:0] acc_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    VALID,
    HOLD
  } state_t;

endpackage

// File: rtl/conv1_mac9.sv
// ---------------------------------------------------------------------------
// conv1_mac9
// Combinational 3x3 window dot product: nine signed 8-bit pixels times nine
// signed 8-bit weights, summed into one signed 24-bit value.
// Ports:
//   pix_win  in  9 x 8   window pixels, tap k = row*3 + col
//   wgt_win  in  9 x 8   kernel weights, same tap order
//   dot      out 24      signed sum of the nine products
// ---------------------------------------------------------------------------
module conv1_mac9
  import conv1_pkg::*;
(
  input  logic [8:0][IN_W-1:0] pix_win,
  input  logic [8:0][IN_W-1:0] wgt_win,
  output logic [OUT_W-1:0]     dot
);

  logic signed [PROD_W-1:0] prod [9];
  acc_t                     sum;

  // Each 8x8 signed product fits in 16 bits (range -16256..16384), so the
  // operands are sign-extended to the product width before multiplying.
  // The nine-term sum stays within +/-147456, far inside 24 bits, so the
  // result is exact and never needs saturation.
  always_comb begin
    sum = '0;
    for (int k = 0; k < 9; k++) begin
      prod[k] = PROD_W'(pix_t'(pix_win[k])) * PROD_W'(pix_t'(wgt_win[k]));
      sum     = sum + acc_t'(prod[k]);
    end
    dot = sum;
  end

endmodule

// File: rtl/conv1_layer.sv
// ---------------------------------------------------------------------------
// conv1_layer
// First NPU convolution layer: 3x3 valid convolution (stride 1, no padding,
// no bias) of one signed 8-bit image against CHAN kernels. One output pixel
// is computed per cycle; each finished feature map is announced with a
// one-cycle out_valid pulse, then the next channel starts.
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   trigger    in   start pulse, only honoured in IDLE
//   in_img     in   [IN1_H][IN1_W] signed 8-bit image
//   w_conv1    in   [K_H][K_W][CHAN] signed 8-bit kernels
//   out_buff   out  [OUT1_H][OUT1_W] signed 24-bit feature map
//   out_valid  out  one-cycle pulse, out_buff holds channel out_chan
//   out_chan   out  channel index of out_buff
// Build option:
//   CONV1_RELU_EN  when defined, negative results are written as 0.
// ---------------------------------------------------------------------------
module conv1_layer
  import conv1_pkg::*;
#(
  parameter int K_H    = 3,
  parameter int K_W    = 3,
  parameter int IN1_H  = 16,
  parameter int IN1_W  = 15,
  parameter int OUT1_H = 14,
  parameter int OUT1_W = 13,
  parameter int CHAN   = 10
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        trigger,
  input  logic [IN1_H-1:0][IN1_W-1:0][IN_W-1:0]       in_img,
  input  logic [K_H-1:0][K_W-1:0][CHAN-1:0][IN_W-1:0] w_conv1,
  output logic [OUT1_H-1:0][OUT1_W-1:0][OUT_W-1:0]    out_buff,
  output logic                                        out_valid,
  output logic [CH_IDX_W-1:0]                         out_chan
);

  // Counters are sized to address the input image so that row+i and col+j
  // window offsets never wrap.
  localparam int RW = $clog2(IN1_H);
  localparam int CW = $clog2(IN1_W);

  localparam logic [RW-1:0]       R_LAST  = RW'(OUT1_H - 1);
  localparam logic [CW-1:0]       C_LAST  = CW'(OUT1_W - 1);
  localparam logic [CH_IDX_W-1:0] CH_LAST = CH_IDX_W'(CHAN - 1);

  state_t                                     state_q, state_d;
  logic [RW-1:0]                              r_q, r_d;
  logic [CW-1:0]                              c_q, c_d;
  logic [CH_IDX_W-1:0]                        ch_q, ch_d;
  logic                                       out_valid_q, out_valid_d;
  logic [OUT1_H-1:0][OUT1_W-1:0][OUT_W-1:0]   out_buff_q, out_buff_d;

  logic [K_H*K_W-1:0][IN_W-1:0]               pix_win;
  logic [K_H*K_W-1:0][IN_W-1:0]               wgt_win;
  logic [OUT_W-1:0]                           mac_dot;
  logic [OUT_W-1:0]                           pix_result;

  // The window anchored at (r_q, c_q) and the current channel's kernel are
  // gathered into tap order row*K_W+col for the MAC.
  for (genvar i = 0; i < K_H; i++) begin : g_row
    for (genvar j = 0; j < K_W; j++) begin : g_col
      logic [RW-1:0] ri;
      logic [CW-1:0] cj;
      assign ri                 = r_q + RW'(i);
      assign cj                 = c_q + CW'(j);
      assign pix_win[i*K_W + j] = in_img[ri][cj];
      assign wgt_win[i*K_W + j] = w_conv1[i][j][ch_q];
    end
  end

  conv1_mac9 u_mac9 (
    .pix_win (pix_win),
    .wgt_win (wgt_win),
    .dot     (mac_dot)
  );

`ifdef CONV1_RELU_EN
  assign pix_result = mac_dot[OUT_W-1] ? '0 : mac_dot;
`else
  assign pix_result = mac_dot;
`endif

  // Sequencer: RUN walks the output map in raster order (column fastest),
  // writing one pixel per cycle. VALID and HOLD each last one cycle with
  // out_buff frozen; HOLD either advances to the next channel or returns
  // to IDLE. Trigger is only looked at in IDLE, so triggers during a run or
  // on the HOLD->IDLE cycle are dropped. out_valid is registered from the
  // RUN->VALID transition so it is high exactly while state_q is VALID.
  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    c_d         = c_q;
    ch_d        = ch_q;
    out_buff_d  = out_buff_q;
    out_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (trigger) begin
          state_d = RUN;
          r_d     = '0;
          c_d     = '0;
          ch_d    = '0;
        end
      end

      RUN: begin
        out_buff_d[r_q][c_q] = pix_result;
        if (c_q == C_LAST) begin
          c_d = '0;
          if (r_q == R_LAST) begin
            r_d         = '0;
            state_d     = VALID;
            out_valid_d = 1'b1;
          end else begin
            r_d = r_q + RW'(1);
          end
        end else begin
          c_d = c_q + CW'(1);
        end
      end

      VALID: begin
        state_d = HOLD;
      end

      HOLD: begin
        if (ch_q == CH_LAST) begin
          state_d = IDLE;
        end else begin
          ch_d    = ch_q + CH_IDX_W'(1);
          state_d = RUN;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // All state, including the feature map, clears immediately on rst so an
  // aborted run can never produce a late out_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      r_q         <= '0;
      c_q         <= '0;
      ch_q        <= '0;
      out_valid_q <= 1'b0;
      out_buff_q  <= '0;
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      c_q         <= c_d;
      ch_q        <= ch_d;
      out_valid_q <= out_valid_d;
      out_buff_q  <= out_buff_d;
    end
  end

  // The channel register doubles as out_chan: it is loaded on entry to RUN
  // for each channel and keeps the last channel while idle.
  assign out_buff  = out_buff_q;
  assign out_valid = out_valid_q;
  assign out_chan  = ch_q;

endmodule

// File: tb/tb_conv1_layer.sv
// ---------------------------------------------------------------------------
// tb_conv1_layer
// Self-checking bench for conv1_layer. A reference model computes each
// output map directly from the convolution definition; a monitor compares
// every announced map, its channel index and the following frozen cycle.
// Directed scenarios pin reset, literal pixel values, pulse timing, ignored
// triggers and abort behaviour.
// ---------------------------------------------------------------------------
module tb_conv1_layer;

  localparam int K_H       = 3;
  localparam int K_W       = 3;
  localparam int IN1_H     = 16;
  localparam int IN1_W     = 15;
  localparam int OUT1_H    = 14;
  localparam int OUT1_W    = 13;
  localparam int CHAN      = 10;
  localparam int RUN_CYC   = OUT1_H * OUT1_W;
  localparam int FIRST_LAT = RUN_CYC + 1;
  localparam int PERIOD    = RUN_CYC + 2;

  logic                                   clk;
  logic                                   rst;
  logic                                   trigger;
  logic [IN1_H-1:0][IN1_W-1:0][7:0]       in_img;
  logic [K_H-1:0][K_W-1:0][CHAN-1:0][7:0] w_conv1;
  logic [OUT1_H-1:0][OUT1_W-1:0][23:0]    out_buff;
  logic                                   out_valid;
  logic [3:0]                             out_chan;

  conv1_layer #(
    .K_H    (K_H),
    .K_W    (K_W),
    .IN1_H  (IN1_H),
    .IN1_W  (IN1_W),
    .OUT1_H (OUT1_H),
    .OUT1_W (OUT1_W),
    .CHAN   (CHAN)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .trigger   (trigger),
    .in_img    (in_img),
    .w_conv1   (w_conv1),
    .out_buff  (out_buff),
    .out_valid (out_valid),
    .out_chan  (out_chan)
  );

  // Clock and free-running edge counter: after posedge number N, cyc == N.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  // Reference image and kernels as plain signed integers.
  int img [IN1_H][IN1_W];
  int wt  [K_H][K_W][CHAN];

  int pulse_count = 0;
  int run_base    = 0;
  int trig_edge   = 0;
  int pulse_edge_q [$];

  task automatic checkOutput(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Convolution straight from its definition, on signed integers.
  function automatic int refPix(input int ch, input int r, input int c);
    int s = 0;
    for (int i = 0; i < K_H; i++)
      for (int j = 0; j < K_W; j++)
        s += img[r+i][c+j] * wt[i][j][ch];
`ifdef CONV1_RELU_EN
    if (s < 0) s = 0;
`endif
    return s;
  endfunction

  // One comparison per whole map; reports the first differing element.
  task automatic checkMap(input string name, input int ch);
    int bad_r = -1;
    int bad_c = -1;
    int got   = 0;
    int want  = 0;
    for (int r = 0; r < OUT1_H; r++) begin
      for (int c = 0; c < OUT1_W; c++) begin
        int g;
        int w;
        g = int'($signed(out_buff[r][c]));
        w = refPix(ch, r, c);
        if (bad_r < 0 && g != w) begin
          bad_r = r;
          bad_c = c;
          got   = g;
          want  = w;
        end
      end
    end
    n_vec++;
    if (bad_r >= 0) begin
      n_err++;
      $display("[TB] FAIL %s ch%0d at (%0d,%0d): got %0d, expected %0d",
               name, ch, bad_r, bad_c, got, want);
    end
  endtask

  function automatic int countNonzero();
    int n = 0;
    for (int r = 0; r < OUT1_H; r++)
      for (int c = 0; c < OUT1_W; c++)
        if (out_buff[r][c] != 24'd0) n++;
    return n;
  endfunction

  // Monitor: on every out_valid, check channel index and map; on the cycle
  // after, out_valid must have dropped and the map must be unchanged.
  int  hold_ch  = 0;
  bit  hold_chk = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      hold_chk = 1'b0;
    end else begin
      if (hold_chk) begin
        checkOutput("hold_valid_low", int'(out_valid), 0);
        checkMap("hold_frozen", hold_ch);
        hold_chk = 1'b0;
      end
      if (out_valid) begin
        checkOutput("out_chan", int'(out_chan), pulse_count - run_base);
        checkMap("map", pulse_count - run_base);
        pulse_edge_q.push_back(cyc + 1);
        hold_ch     = pulse_count - run_base;
        pulse_count = pulse_count + 1;
        hold_chk    = 1'b1;
      end
    end
  end

  // mode 0: in_img = s8(i*15+j), w = i*3+j+k; mode 1: all -128;
  // mode 2: pixels -128, weights 127.
  task automatic loadPattern(input int mode);
    for (int i = 0; i < IN1_H; i++) begin
      for (int j = 0; j < IN1_W; j++) begin
        img[i][j]    = (mode == 0) ? int'($signed(8'(i*IN1_W + j))) : -128;
        in_img[i][j] = 8'(img[i][j]);
      end
    end
    for (int i = 0; i < K_H; i++) begin
      for (int j = 0; j < K_W; j++) begin
        for (int k = 0; k < CHAN; k++) begin
          wt[i][j][k]      = (mode == 0) ? (i*3 + j + k) : ((mode == 1) ? -128 : 127);
          w_conv1[i][j][k] = 8'(wt[i][j][k]);
        end
      end
    end
  endtask

  task automatic waitUntilCycle(input int target);
    while (cyc < target) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic pulseTrigger();
    trigger = 1'b1;
    @(negedge clk);
    #1;
    trigger = 1'b0;
  endtask

  // Loads a pattern and starts a run; trig_edge is the edge that sampled it.
  task automatic applyStimulus(input int mode);
    loadPattern(mode);
    run_base = pulse_count;
    pulseTrigger();
    trig_edge = cyc;
  endtask

  task automatic checkRunTiming(input string name);
    checkOutput({name, "_pulses"}, pulse_count - run_base, CHAN);
    for (int k = 0; k < CHAN; k++) begin
      int e;
      e = (run_base + k < pulse_edge_q.size()) ? pulse_edge_q[run_base + k] - trig_edge : -1;
      checkOutput({name, "_pulse_edge"}, e, FIRST_LAT + k*PERIOD);
    end
  endtask

  initial begin
    int abort_count;

    rst     = 1'b1;
    trigger = 1'b0;
    in_img  = '0;
    w_conv1 = '0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset_valid", int'(out_valid), 0);
    checkOutput("reset_chan", int'(out_chan), 0);
    checkOutput("reset_buff_nonzero", countNonzero(), 0);
    rst = 1'b0;
    waitUntilCycle(cyc + 500);
    checkOutput("idle_no_pulse", pulse_count, 0);

    // Default pattern, with a trigger mid-run and one on the HOLD->IDLE edge
    applyStimulus(0);
    waitUntilCycle(trig_edge + RUN_CYC);
    checkOutput("first_valid", int'(out_valid), 1);
    checkOutput("ch0_px00", int'($signed(out_buff[0][0])), 852);
    checkOutput("ch0_px_last", int'($signed(out_buff[OUT1_H-1][OUT1_W-1])), -912);
    waitUntilCycle(trig_edge + 2*PERIOD + 50);
    pulseTrigger();
    waitUntilCycle(trig_edge + RUN_CYC + (CHAN-1)*PERIOD + 1);
    pulseTrigger();
    waitUntilCycle(cyc + 400);
    checkRunTiming("default");
    checkOutput("idle_chan", int'(out_chan), CHAN-1);
    checkOutput("idle_valid", int'(out_valid), 0);
    checkMap("idle_keep", CHAN-1);

    // Extremes: -128 * -128 everywhere
    applyStimulus(1);
    waitUntilCycle(trig_edge + RUN_CYC);
    checkOutput("ext_px00", int'($signed(out_buff[0][0])), 147456);
    checkOutput("ext_px_last", int'($signed(out_buff[OUT1_H-1][OUT1_W-1])), 147456);
    waitUntilCycle(trig_edge + RUN_CYC + (CHAN-1)*PERIOD + 10);
    checkRunTiming("extreme");

    // Mixed signs: -128 * 127 everywhere
    applyStimulus(2);
    waitUntilCycle(trig_edge + RUN_CYC);
    checkOutput("mix_px00", int'($signed(out_buff[0][0])), -146304);
    checkOutput("mix_px_last", int'($signed(out_buff[OUT1_H-1][OUT1_W-1])), -146304);
    waitUntilCycle(trig_edge + RUN_CYC + (CHAN-1)*PERIOD + 10);
    checkRunTiming("mixed");

    // Abort during channel 3, then a clean restart
    applyStimulus(0);
    waitUntilCycle(trig_edge + 3*PERIOD + 60);
    checkOutput("pre_abort_chan", int'(out_chan), 3);
    abort_count = pulse_count;
    rst = 1'b1;
    #2;
    checkOutput("abort_valid", int'(out_valid), 0);
    checkOutput("abort_chan", int'(out_chan), 0);
    checkOutput("abort_buff_nonzero", countNonzero(), 0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    waitUntilCycle(cyc + 400);
    checkOutput("abort_no_pulse", pulse_count - abort_count, 0);
    applyStimulus(0);
    waitUntilCycle(trig_edge + RUN_CYC + (CHAN-1)*PERIOD + 10);
    checkRunTiming("restart");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
